// File: rtl/mem_arb_pkg.sv
// Shared types and limits for the memory port arbiter.
// Imported by the arbiter top and its priority sub-module.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } arb_owner_t;

    localparam int RAM_LAT_MIN    = 1;
    localparam int RAM_LAT_MAX    = 4;
    localparam int STARVE_MAX_LIM = 15;

    localparam int CNT_W = 3;
    localparam int SC_W  = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request, response and RAM-side signals of the memory port arbiter.
// The arbiter uses the slave view; requesters and the RAM use master.
interface mem_port_arbiter_if;

    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;

    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_ack;

    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_we;
    logic [31:0] ram_rdata;

    logic        stall_pc;

    modport slave (
        input  if_req,
        input  if_addr,
        output if_rdata,
        output if_ack,
        input  dm_req,
        input  dm_we,
        input  dm_addr,
        input  dm_wdata,
        output dm_rdata,
        output dm_ack,
        output ram_addr,
        output ram_wdata,
        output ram_we,
        input  ram_rdata,
        output stall_pc
    );

    modport master (
        output if_req,
        output if_addr,
        input  if_rdata,
        input  if_ack,
        output dm_req,
        output dm_we,
        output dm_addr,
        output dm_wdata,
        input  dm_rdata,
        input  dm_ack,
        input  ram_addr,
        input  ram_wdata,
        input  ram_we,
        output ram_rdata,
        input  stall_pc
    );

endinterface

// File: rtl/mem_arb_priority.sv
// DM-first grant selection with an anti-starvation counter for IF.
// The counter only moves on cycles where the FSM actually grants.
module mem_arb_priority
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       if_req,
    input  logic       dm_req,
    input  logic       grant_en,
    output arb_owner_t owner
);

    localparam logic [SC_W-1:0] SMAX = SC_W'(STARVE_MAX);
    localparam logic [SC_W-1:0] ONE  = SC_W'(1);

    logic [SC_W-1:0] starve_cnt_q;
    logic [SC_W-1:0] starve_cnt_d;
    logic            if_starved;

    assign if_starved = if_req && (starve_cnt_q == SMAX);

    always_comb begin
        owner = OWN_IF;
        if (dm_req && !if_starved) begin
            owner = OWN_DM;
        end
    end

    // Only DM grants made against a waiting IF count as starvation.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (grant_en) begin
            if (owner == OWN_IF) begin
                starve_cnt_d = '0;
            end else if (if_req && (starve_cnt_q != SMAX)) begin
                starve_cnt_d = starve_cnt_q + ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Sequences one single-port RAM between the fetch and data ports,
// one access in flight, with a fixed-latency BUSY countdown.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int RAM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_port_arbiter_if.slave   bus
);

    localparam logic [CNT_W-1:0] LAT = CNT_W'(RAM_LAT);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    arb_state_t       state_q, state_d;
    arb_owner_t       owner_q, owner_d;
    arb_owner_t       grant_owner;
    logic             grant_en;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wr_q, wr_d;
    logic [31:0]      ram_addr_q, ram_addr_d;
    logic [31:0]      ram_wdata_q, ram_wdata_d;
    logic             ram_we_q, ram_we_d;
    logic [31:0]      if_rdata_q, if_rdata_d;
    logic [31:0]      dm_rdata_q, dm_rdata_d;
    logic             if_ack_q, if_ack_d;
    logic             dm_ack_q, dm_ack_d;

    mem_arb_priority #(
        .STARVE_MAX (STARVE_MAX)
    ) u_prio (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_req   (bus.if_req),
        .dm_req   (bus.dm_req),
        .grant_en (grant_en),
        .owner    (grant_owner)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        wr_d        = wr_q;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        ram_we_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_ack_d    = 1'b0;
        dm_ack_d    = 1'b0;
        grant_en    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.if_req || bus.dm_req) begin
                    grant_en = 1'b1;
                    owner_d  = grant_owner;
                    cnt_d    = LAT;
                    state_d  = BUSY;
                    if (grant_owner == OWN_DM) begin
                        ram_addr_d  = bus.dm_addr;
                        ram_wdata_d = bus.dm_wdata;
                        wr_d        = bus.dm_we;
                        ram_we_d    = bus.dm_we;
                    end else begin
                        ram_addr_d = bus.if_addr;
                        wr_d       = 1'b0;
                    end
                end
            end
            BUSY: begin
                // A zero count means ram_rdata is valid this cycle.
                if (cnt_q == '0) begin
                    state_d = DONE;
                    if (owner_q == OWN_DM) begin
                        dm_ack_d = 1'b1;
                        if (!wr_q) begin
                            dm_rdata_d = bus.ram_rdata;
                        end
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = bus.ram_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_we_q    <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_we_q    <= ram_we_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_ack_q    <= if_ack_d;
            dm_ack_q    <= dm_ack_d;
        end
    end

    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.dm_ack    = dm_ack_q;
    assign bus.stall_pc  = bus.if_req & ~if_ack_q;

endmodule
